dram_port_responder: RTL and testbench

- Memory-side responder for the per-hart DRAM request port driven by each CPU/MMU wrapper (addr, wdata, ctrl, we_t, le in; busy, odata out).
- Serves two harts: latches each hart's strobed request, arbitrates round-robin, and performs byte-lane alignment and load extension.
- Drives one shared backing-memory req/ack port and publishes the current bus owner on w_grant.
- Sits between the hart wrappers and the DRAM/BRAM controller.

---
 rtl/dram_port_responder_pkg.sv | 42 ++++
 rtl/dram_port_responder_m_lane_align.sv | 53 +++++
 rtl/dram_port_responder.sv | 149 ++++++++++++++
 tb/tb_dram_port_responder.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_port_responder_pkg.sv
// Shared definitions for the two-hart DRAM port responder: access codes,
// FSM encoding and the latched request record.
package dram_port_responder_pkg;

  localparam int NHARTS = 2;

  localparam logic [2:0] LB  = 3'd0;
  localparam logic [2:0] LH  = 3'd1;
  localparam logic [2:0] LW  = 3'd2;
  localparam logic [2:0] LBU = 3'd4;
  localparam logic [2:0] LHU = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  ctrl;
    logic        we;
  } req_t;

  // Unsigned variants share the size of their signed twins; unknown codes act as word.
  function automatic size_e ctrl_size(input logic [2:0] ctrl);
    case (ctrl)
      LB, LBU: return SZ_B;
      LH, LHU: return SZ_H;
      default: return SZ_W;
    endcase
  endfunction

endpackage

// File: rtl/dram_port_responder_m_lane_align.sv
// Byte-lane steering for one access: store replication and strobes,
// load extraction with sign/zero extension, and the misalignment flag.
module dram_port_responder_m_lane_align
  import dram_port_responder_pkg::*;
(
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  ctrl_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] wdata_o,
  output logic [3:0]  wstrb_o,
  output logic [31:0] rdata_o,
  output logic        misalign_o
);

  size_e       size;
  logic        sext;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    size       = ctrl_size(ctrl_i);
    sext       = (ctrl_i == LB) || (ctrl_i == LH);
    half_sel   = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    byte_sel   = rdata_i[7:0];
    case (addr_lo_i)
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      2'd3:    byte_sel = rdata_i[31:24];
      default: byte_sel = rdata_i[7:0];
    endcase

    wdata_o    = wdata_i;
    wstrb_o    = 4'b1111;
    rdata_o    = rdata_i;
    misalign_o = 1'b0;
    case (size)
      SZ_B: begin
        wdata_o = {4{wdata_i[7:0]}};
        wstrb_o = 4'b0001 << addr_lo_i;
        rdata_o = {{24{sext & byte_sel[7]}}, byte_sel};
      end
      SZ_H: begin
        wdata_o    = {2{wdata_i[15:0]}};
        wstrb_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        rdata_o    = {{16{sext & half_sel[15]}}, half_sel};
        misalign_o = addr_lo_i[0];
      end
      default: misalign_o = (addr_lo_i != 2'b00);
    endcase
  end

endmodule

// File: rtl/dram_port_responder.sv
// Memory-side responder for two hart DRAM ports: latches strobed requests,
// arbitrates round-robin onto one req/ack backing port and returns extended loads.
module dram_port_responder
  import dram_port_responder_pkg::*;
#(
  parameter int   ADDR_W  = 32,
  parameter logic RR_INIT = 1'b0
) (
  input  logic              CLK,
  input  logic              RST_X,
  input  logic [31:0]       w_h0_addr,
  input  logic [31:0]       w_h0_wdata,
  input  logic [2:0]        w_h0_ctrl,
  input  logic              w_h0_we,
  input  logic              w_h0_le,
  input  logic [31:0]       w_h1_addr,
  input  logic [31:0]       w_h1_wdata,
  input  logic [2:0]        w_h1_ctrl,
  input  logic              w_h1_we,
  input  logic              w_h1_le,
  output logic              w_h0_busy,
  output logic [31:0]       w_h0_odata,
  output logic              w_h1_busy,
  output logic [31:0]       w_h1_odata,
  output logic [31:0]       w_grant,
  output logic [1:0]        w_misalign,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  output logic [3:0]        o_mem_wstrb,
  input  logic              i_mem_ack,
  input  logic [31:0]       i_mem_rdata
);

  req_t              req_in [NHARTS];
  req_t              lat_q  [NHARTS];
  req_t              cur;
  logic [NHARTS-1:0] strobe, cap;
  logic [NHARTS-1:0] pend_q, pend_d;
  state_e            state_q, state_d;
  logic              sel_q, sel_d;
  logic              rr_q, rr_d;
  logic [31:0]       odata_q [NHARTS];
  logic              od_we;
  logic [31:0]       od_val;
  logic              mem_req;
  logic [1:0]        mis_pulse;
  logic [31:0]       st_data, ld_data;
  logic [3:0]        st_strb;
  logic              misal;

  assign req_in[0] = '{addr: w_h0_addr, wdata: w_h0_wdata, ctrl: w_h0_ctrl, we: w_h0_we};
  assign req_in[1] = '{addr: w_h1_addr, wdata: w_h1_wdata, ctrl: w_h1_ctrl, we: w_h1_we};
  assign strobe    = {w_h1_we | w_h1_le, w_h0_we | w_h0_le};
  // A strobe arriving while that hart is still pending is dropped.
  assign cap       = strobe & ~pend_q;
  assign cur       = lat_q[sel_q];

  dram_port_responder_m_lane_align u_m_lane_align (
    .addr_lo_i  (cur.addr[1:0]),
    .ctrl_i     (cur.ctrl),
    .wdata_i    (cur.wdata),
    .rdata_i    (i_mem_rdata),
    .wdata_o    (st_data),
    .wstrb_o    (st_strb),
    .rdata_o    (ld_data),
    .misalign_o (misal)
  );

  always_ff @(posedge CLK) begin
    for (int h = 0; h < NHARTS; h++)
      if (cap[h]) lat_q[h] <= req_in[h];
  end

  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q | cap;
    sel_d     = sel_q;
    rr_d      = rr_q;
    od_we     = 1'b0;
    od_val    = 32'd0;
    mem_req   = 1'b0;
    mis_pulse = 2'b00;
    case (state_q)
      // Arbitration sees this cycle's strobes so capture and selection share an edge.
      ST_IDLE: begin
        if (|pend_d) begin
          sel_d   = (&pend_d) ? rr_q : pend_d[1];
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (misal) begin
          mis_pulse[sel_q] = 1'b1;
          od_we            = ~cur.we;
          state_d          = ST_DONE;
        end else begin
          mem_req = 1'b1;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        mem_req = 1'b1;
        if (i_mem_ack) begin
          od_we   = ~cur.we;
          od_val  = ld_data;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        pend_d[sel_q] = 1'b0;
        rr_d          = ~sel_q;
        state_d       = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      state_q    <= ST_IDLE;
      pend_q     <= '0;
      sel_q      <= RR_INIT;
      rr_q       <= RR_INIT;
      odata_q[0] <= 32'd0;
      odata_q[1] <= 32'd0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      sel_q   <= sel_d;
      rr_q    <= rr_d;
      if (od_we) odata_q[sel_q] <= od_val;
    end
  end

  assign w_h0_busy   = pend_q[0] | strobe[0];
  assign w_h1_busy   = pend_q[1] | strobe[1];
  assign w_h0_odata  = odata_q[0];
  assign w_h1_odata  = odata_q[1];
  assign w_grant     = {31'd0, sel_q};
  assign w_misalign  = mis_pulse;
  assign o_mem_req   = mem_req;
  assign o_mem_we    = mem_req & cur.we;
  assign o_mem_addr  = {cur.addr[ADDR_W-1:2], 2'b00};
  assign o_mem_wdata = st_data;
  assign o_mem_wstrb = (mem_req & cur.we) ? st_strb : 4'b0000;

endmodule

// File: tb/tb_dram_port_responder.sv
// Scoreboard bench for dram_port_responder: expected backing requests and
// per-hart load results are queued at stimulus time and checked as they appear.
module tb_dram_port_responder;

  typedef struct packed {
    logic        hart;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
  } mexp_t;

  logic        CLK = 1'b0;
  logic        RST_X = 1'b0;
  logic [31:0] h_addr [2];
  logic [31:0] h_wdata [2];
  logic [2:0]  h_ctrl [2];
  logic        h_we [2];
  logic        h_le [2];
  logic        busy0, busy1;
  logic [31:0] od0, od1;
  logic [31:0] w_grant;
  logic [1:0]  w_misalign;
  logic        o_mem_req, o_mem_we;
  logic [31:0] o_mem_addr, o_mem_wdata;
  logic [3:0]  o_mem_wstrb;
  logic        i_mem_ack = 1'b0;
  logic [31:0] i_mem_rdata = 32'd0;

  int          tests_run = 0;
  int          tests_failed = 0;
  mexp_t       mq [$];
  logic [31:0] odq0 [$];
  logic [31:0] odq1 [$];
  logic [31:0] model_od [2];
  int          busy_cnt [2];
  int          nreq;
  logic [1:0]  seen_mis;

  always #5 CLK = ~CLK;

  dram_port_responder #(.ADDR_W(32), .RR_INIT(1'b0)) dut (
    .CLK(CLK), .RST_X(RST_X),
    .w_h0_addr(h_addr[0]), .w_h0_wdata(h_wdata[0]), .w_h0_ctrl(h_ctrl[0]),
    .w_h0_we(h_we[0]), .w_h0_le(h_le[0]),
    .w_h1_addr(h_addr[1]), .w_h1_wdata(h_wdata[1]), .w_h1_ctrl(h_ctrl[1]),
    .w_h1_we(h_we[1]), .w_h1_le(h_le[1]),
    .w_h0_busy(busy0), .w_h0_odata(od0), .w_h1_busy(busy1), .w_h1_odata(od1),
    .w_grant(w_grant), .w_misalign(w_misalign),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .o_mem_wstrb(o_mem_wstrb),
    .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata)
  );

  task automatic clear_strobes();
    for (int h = 0; h < 2; h++) begin
      h_we[h] = 1'b0;
      h_le[h] = 1'b0;
    end
  endtask

  task automatic issue(input int h, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [2:0] ctrl, input logic we, input logic le);
    h_addr[h]  = addr;
    h_wdata[h] = wdata;
    h_ctrl[h]  = ctrl;
    h_we[h]    = we;
    h_le[h]    = le;
  endtask

  task automatic push_mem(input logic hart, input logic [31:0] addr, input logic we,
                          input logic [31:0] wdata, input logic [3:0] wstrb, input logic [31:0] rdata);
    mexp_t e;
    e.hart = hart; e.addr = addr; e.we = we; e.wdata = wdata; e.wstrb = wstrb; e.rdata = rdata;
    mq.push_back(e);
  endtask

  task automatic push_od(input int h, input logic [31:0] v);
    model_od[h] = v;
    if (h == 0) odq0.push_back(v);
    else odq1.push_back(v);
  endtask

  // Plays the backing memory (ack in the first WAIT cycle) and checks outputs until both harts go idle.
  task automatic run(input int max_cyc);
    logic       rp, done;
    logic [1:0] b, bp;
    logic [31:0] cur_rdata, exp_od;
    mexp_t      e;
    rp = 1'b0; bp = 2'b00; done = 1'b0; cur_rdata = 32'd0;
    nreq = 0; seen_mis = 2'b00; busy_cnt[0] = 0; busy_cnt[1] = 0;
    for (int c = 0; c < max_cyc && !done; c++) begin
      if (c > 0) begin
        @(negedge CLK);
        clear_strobes();
      end
      #1;
      b = {busy1, busy0};
      seen_mis |= w_misalign;
      for (int h = 0; h < 2; h++) if (b[h]) busy_cnt[h]++;
      if (bp[0] && !b[0]) begin
        exp_od = (odq0.size() > 0) ? odq0.pop_front() : 32'hDEADDEAD;
        tests_run++;
        if (od0 !== exp_od) begin
          tests_failed++;
          $display("FAIL h0_odata got=%h want=%h", od0, exp_od);
        end
      end
      if (bp[1] && !b[1]) begin
        exp_od = (odq1.size() > 0) ? odq1.pop_front() : 32'hDEADDEAD;
        tests_run++;
        if (od1 !== exp_od) begin
          tests_failed++;
          $display("FAIL h1_odata got=%h want=%h", od1, exp_od);
        end
      end
      if (o_mem_req && !rp) begin
        nreq++;
        tests_run++;
        i_mem_ack = 1'b0;
        if (mq.size() == 0) begin
          tests_failed++;
          cur_rdata = 32'd0;
          $display("FAIL unexpected_req addr=%h we=%b", o_mem_addr, o_mem_we);
        end else begin
          e = mq.pop_front();
          cur_rdata = e.rdata;
          if (o_mem_addr !== e.addr || o_mem_we !== e.we || o_mem_wstrb !== e.wstrb ||
              (e.we && o_mem_wdata !== e.wdata) || w_grant !== {31'd0, e.hart}) begin
            tests_failed++;
            $display("FAIL mem_req got addr=%h we=%b wdata=%h wstrb=%b grant=%0d want addr=%h we=%b wdata=%h wstrb=%b grant=%0d",
                     o_mem_addr, o_mem_we, o_mem_wdata, o_mem_wstrb, w_grant,
                     e.addr, e.we, e.wdata, e.wstrb, e.hart);
          end
        end
      end else if (o_mem_req && rp) begin
        i_mem_ack   = 1'b1;
        i_mem_rdata = cur_rdata;
      end else begin
        i_mem_ack = 1'b0;
      end
      bp = b;
      rp = o_mem_req;
      if (b == 2'b00) done = 1'b1;
    end
    i_mem_ack = 1'b0;
    clear_strobes();
    tests_run++;
    if (!done || mq.size() != 0) begin
      tests_failed++;
      $display("FAIL run_complete idle=%b left_mem=%0d want idle=1 left_mem=0", done, mq.size());
      mq.delete();
    end
  endtask

  task automatic test_reset();
    RST_X = 1'b0;
    clear_strobes();
    i_mem_ack = 1'b0;
    repeat (2) @(negedge CLK);
    #1;
    tests_run++;
    if (busy0 !== 1'b0 || busy1 !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_busy got=%b%b want=00", busy1, busy0);
    end
    tests_run++;
    if (od0 !== 32'd0 || od1 !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_odata got=%h/%h want=0/0", od0, od1);
    end
    tests_run++;
    if (w_grant !== 32'd0 || w_misalign !== 2'b00) begin
      tests_failed++;
      $display("FAIL reset_grant got grant=%0d mis=%b want 0/00", w_grant, w_misalign);
    end
    tests_run++;
    if (o_mem_req !== 1'b0 || o_mem_we !== 1'b0 || o_mem_wstrb !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_mem got req=%b we=%b wstrb=%b want 0/0/0000", o_mem_req, o_mem_we, o_mem_wstrb);
    end
    @(negedge CLK);
    RST_X = 1'b1;
    model_od[0] = 32'd0;
    model_od[1] = 32'd0;
    odq0.delete();
    odq1.delete();
  endtask

  task automatic test_load_word();
    @(negedge CLK);
    issue(0, 32'h80000004, 32'd0, 3'd2, 1'b0, 1'b1);
    push_mem(1'b0, 32'h80000004, 1'b0, 32'd0, 4'b0000, 32'h11223344);
    push_od(0, 32'h11223344);
    run(40);
    tests_run++;
    if (busy_cnt[0] != 4) begin
      tests_failed++;
      $display("FAIL lw_busy_cycles got=%0d want=4", busy_cnt[0]);
    end
  endtask

  task automatic test_store();
    @(negedge CLK);
    issue(1, 32'h80000003, 32'h000000A5, 3'd0, 1'b1, 1'b0);
    push_mem(1'b1, 32'h80000000, 1'b1, 32'hA5A5A5A5, 4'b1000, 32'd0);
    push_od(1, model_od[1]);
    run(40);
    @(negedge CLK);
    issue(1, 32'h80000002, 32'h1234BEEF, 3'd1, 1'b1, 1'b0);
    push_mem(1'b1, 32'h80000000, 1'b1, 32'hBEEFBEEF, 4'b1100, 32'd0);
    push_od(1, model_od[1]);
    run(40);
    @(negedge CLK);
    issue(0, 32'h80000008, 32'hDEADBEEF, 3'd2, 1'b1, 1'b0);
    push_mem(1'b0, 32'h80000008, 1'b1, 32'hDEADBEEF, 4'b1111, 32'd0);
    push_od(0, model_od[0]);
    run(40);
    @(negedge CLK);
    issue(0, 32'h80000001, 32'h0000005A, 3'd4, 1'b1, 1'b0);
    push_mem(1'b0, 32'h80000000, 1'b1, 32'h5A5A5A5A, 4'b0010, 32'd0);
    push_od(0, model_od[0]);
    run(40);
    @(negedge CLK);
    issue(0, 32'h80000010, 32'h0000003C, 3'd0, 1'b1, 1'b1);
    push_mem(1'b0, 32'h80000010, 1'b1, 32'h3C3C3C3C, 4'b0001, 32'hFFFFFFFF);
    push_od(0, model_od[0]);
    run(40);
  endtask

  task automatic test_load_extend();
    logic [31:0] a [6];
    logic [2:0]  c [6];
    logic [31:0] r [6];
    logic [31:0] x [6];
    logic [31:0] wa [6];
    a[0] = 32'h80000001; c[0] = 3'd0; r[0] = 32'h0000F000; x[0] = 32'hFFFFFFF0; wa[0] = 32'h80000000;
    a[1] = 32'h80000001; c[1] = 3'd4; r[1] = 32'h0000F000; x[1] = 32'h000000F0; wa[1] = 32'h80000000;
    a[2] = 32'h80000002; c[2] = 3'd1; r[2] = 32'h80010000; x[2] = 32'hFFFF8001; wa[2] = 32'h80000000;
    a[3] = 32'h80000002; c[3] = 3'd5; r[3] = 32'h80010000; x[3] = 32'h00008001; wa[3] = 32'h80000000;
    a[4] = 32'h80000007; c[4] = 3'd0; r[4] = 32'h7F000000; x[4] = 32'h0000007F; wa[4] = 32'h80000004;
    a[5] = 32'h8000000C; c[5] = 3'd3; r[5] = 32'hCAFEF00D; x[5] = 32'hCAFEF00D; wa[5] = 32'h8000000C;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      issue(i % 2, a[i], 32'd0, c[i], 1'b0, 1'b1);
      push_mem(1'((i % 2) != 0), wa[i], 1'b0, 32'd0, 4'b0000, r[i]);
      push_od(i % 2, x[i]);
      run(40);
    end
  endtask

  task automatic test_back_to_back();
    test_reset();
    @(negedge CLK);
    issue(0, 32'h80000010, 32'd0, 3'd2, 1'b0, 1'b1);
    issue(1, 32'h80000020, 32'd0, 3'd2, 1'b0, 1'b1);
    push_mem(1'b0, 32'h80000010, 1'b0, 32'd0, 4'b0000, 32'hAAAA0000);
    push_mem(1'b1, 32'h80000020, 1'b0, 32'd0, 4'b0000, 32'h0000BBBB);
    push_od(0, 32'hAAAA0000);
    push_od(1, 32'h0000BBBB);
    run(60);
    tests_run++;
    if (nreq != 2 || w_grant !== 32'd1) begin
      tests_failed++;
      $display("FAIL rr_first_pair got nreq=%0d grant=%0d want 2/1", nreq, w_grant);
    end
    @(negedge CLK);
    issue(0, 32'h80000030, 32'd0, 3'd2, 1'b0, 1'b1);
    push_mem(1'b0, 32'h80000030, 1'b0, 32'd0, 4'b0000, 32'h01020304);
    push_od(0, 32'h01020304);
    run(40);
    @(negedge CLK);
    issue(0, 32'h80000040, 32'd0, 3'd2, 1'b0, 1'b1);
    issue(1, 32'h80000050, 32'd0, 3'd2, 1'b0, 1'b1);
    push_mem(1'b1, 32'h80000050, 1'b0, 32'd0, 4'b0000, 32'h55550001);
    push_mem(1'b0, 32'h80000040, 1'b0, 32'd0, 4'b0000, 32'h66660002);
    push_od(0, 32'h66660002);
    push_od(1, 32'h55550001);
    run(60);
    repeat (3) @(negedge CLK);
    #1;
    tests_run++;
    if (w_grant !== 32'd0) begin
      tests_failed++;
      $display("FAIL grant_hold_idle got=%0d want=0", w_grant);
    end
  endtask

  task automatic test_misalign();
    @(negedge CLK);
    issue(1, 32'h80000002, 32'd0, 3'd2, 1'b0, 1'b1);
    push_od(1, 32'd0);
    run(40);
    tests_run++;
    if (nreq != 0 || seen_mis !== 2'b10) begin
      tests_failed++;
      $display("FAIL misalign_lw got nreq=%0d mis=%b want 0/10", nreq, seen_mis);
    end
    @(negedge CLK);
    issue(0, 32'h80000001, 32'h00001234, 3'd1, 1'b1, 1'b0);
    push_od(0, model_od[0]);
    run(40);
    tests_run++;
    if (nreq != 0 || seen_mis !== 2'b01) begin
      tests_failed++;
      $display("FAIL misalign_sh got nreq=%0d mis=%b want 0/01", nreq, seen_mis);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge CLK);
    issue(0, 32'h80000060, 32'd0, 3'd2, 1'b0, 1'b1);
    @(negedge CLK);
    clear_strobes();
    @(negedge CLK);
    #1;
    tests_run++;
    if (o_mem_req !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_mid_wait_req got=%b want=1", o_mem_req);
    end
    RST_X = 1'b0;
    #1;
    tests_run++;
    if (o_mem_req !== 1'b0 || busy0 !== 1'b0 || busy1 !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_mid_drop got req=%b busy=%b%b want 0/00", o_mem_req, busy1, busy0);
    end
    @(negedge CLK);
    RST_X = 1'b1;
    i_mem_ack = 1'b1;
    i_mem_rdata = 32'hFFFFFFFF;
    @(negedge CLK);
    i_mem_ack = 1'b0;
    repeat (2) @(negedge CLK);
    #1;
    tests_run++;
    if (o_mem_req !== 1'b0 || busy0 !== 1'b0 || od0 !== 32'd0) begin
      tests_failed++;
      $display("FAIL rst_late_ack got req=%b busy0=%b od0=%h want 0/0/0", o_mem_req, busy0, od0);
    end
  endtask

  initial begin
    for (int h = 0; h < 2; h++) begin
      h_addr[h] = 32'd0; h_wdata[h] = 32'd0; h_ctrl[h] = 3'd0;
      h_we[h] = 1'b0; h_le[h] = 1'b0;
    end
    test_reset();
    test_load_word();
    test_store();
    test_load_extend();
    test_back_to_back();
    test_misalign();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
